ascon_state_reader: RTL and testbench

Read side of the ASCON 320-bit state register. The block captures a `type_state` value (five 64-bit words x0..x4) on a start pulse and streams a configurable contiguous range of its words out, one 64-bit word per transfer, over a valid/ready handshake. It sits between the permutation datapath's state register and the output formatter (ciphertext/tag emission). The internal shadow copy frees the source register as soon as capture completes.

---
 rtl/ascon_state_reader_if.sv | 16 +
 rtl/ascon_state_reader.sv | 61 ++++++
 tb/tb_ascon_state_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ascon_state_reader_if.sv
// ascon_state_reader_if: start/state capture inputs and word-stream handshake of the state reader.
interface ascon_state_reader_if;
   logic             start_i;
   logic [4:0][63:0] state_i;
   logic             ready_i;
   logic             valid_o;
   logic [63:0]      word_o;
   logic [2:0]       index_o;
   logic             last_o;
   logic             busy_o;
   logic             done_o;
   modport master (output start_i, state_i, ready_i,
                   input valid_o, word_o, index_o, last_o, busy_o, done_o);
   modport slave  (input start_i, state_i, ready_i,
                   output valid_o, word_o, index_o, last_o, busy_o, done_o);
endinterface

// File: rtl/ascon_state_reader.sv
// ascon_state_reader: captures the 320-bit ASCON state and streams words START_WORD.. over valid/ready.
// Define ASCON_READER_BYTESWAP_EN to present each word byte-reversed (little-endian) on word_o.
module ascon_state_reader #(
   parameter int START_WORD = 0,
   parameter int NB_WORDS   = 5
) (
   input logic                  clock_i,
   input logic                  reset_i,
   ascon_state_reader_if.slave  bus
);
   if (NB_WORDS < 1 || START_WORD < 0 || START_WORD + NB_WORDS > 5) begin : g_bad_range
      $error("ascon_state_reader: START_WORD + NB_WORDS must lie within 1..5 words");
   end
   localparam logic [2:0] FIRST = 3'(START_WORD);
   localparam logic [2:0] LAST  = 3'(START_WORD + NB_WORDS - 1);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   state_t           state, state_nx;
   logic [4:0][63:0] shadow, shadow_nx;
   logic [2:0]       cnt, cnt_nx;
   logic [63:0]      cur;
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state  <= IDLE;
         shadow <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nx;
         shadow <= shadow_nx;
         cnt    <= cnt_nx;
      end
   end
   always_comb begin
      state_nx  = state;
      shadow_nx = shadow;
      cnt_nx    = cnt;
      case (state)
         IDLE: if (bus.start_i) begin
            state_nx  = SEND;
            shadow_nx = bus.state_i;
            cnt_nx    = FIRST;
         end
         SEND: if (bus.ready_i) begin
            if (cnt == LAST) state_nx = DONE;
            else cnt_nx = cnt + 3'd1;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
`ifdef ASCON_READER_BYTESWAP_EN
   assign cur = {<<8{shadow[cnt]}};
`else
   assign cur = shadow[cnt];
`endif
   assign bus.valid_o = state == SEND;
   assign bus.word_o  = bus.valid_o ? cur : '0;
   assign bus.index_o = bus.valid_o ? cnt : '0;
   assign bus.last_o  = bus.valid_o && cnt == LAST;
   assign bus.busy_o  = state != IDLE;
   assign bus.done_o  = state == DONE;
endmodule

// File: tb/tb_ascon_state_reader.sv
// tb_ascon_state_reader: default reader and a 3/2 tag-readout reader against a word-sequence model.
module tb_ascon_state_reader;
   logic             clk = 0;
   logic             rst, start_a, start_b, rdy;
   logic [4:0][63:0] st;
   bit               sel;
   int               total = 0, bad = 0;
   logic             o_valid, o_last, o_busy, o_done;
   logic [63:0]      o_word;
   logic [2:0]       o_index;
   ascon_state_reader_if ia();
   ascon_state_reader_if ib();
   assign ia.start_i = start_a;
   assign ib.start_i = start_b;
   assign ia.state_i = st;
   assign ib.state_i = st;
   assign ia.ready_i = rdy;
   assign ib.ready_i = rdy;
   ascon_state_reader dut_a (.clock_i(clk), .reset_i(rst), .bus(ia.slave));
   ascon_state_reader #(.START_WORD(3), .NB_WORDS(2)) dut_b (.clock_i(clk), .reset_i(rst), .bus(ib.slave));
   always #5 clk = ~clk;
   always_comb begin
      o_valid = sel ? ib.valid_o : ia.valid_o;
      o_word  = sel ? ib.word_o  : ia.word_o;
      o_index = sel ? ib.index_o : ia.index_o;
      o_last  = sel ? ib.last_o  : ia.last_o;
      o_busy  = sel ? ib.busy_o  : ia.busy_o;
      o_done  = sel ? ib.done_o  : ia.done_o;
   end
   function automatic logic [63:0] sw64(input logic [63:0] w);
      logic [63:0] r;
      r = w;
`ifdef ASCON_READER_BYTESWAP_EN
      for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
`endif
      return r;
   endfunction
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 64'(o_valid), 64'd0);
      check({tag, ".word"},  o_word, 64'd0);
      check({tag, ".index"}, 64'(o_index), 64'd0);
      check({tag, ".last"},  64'(o_last), 64'd0);
      check({tag, ".busy"},  64'(o_busy), 64'd0);
      check({tag, ".done"},  64'(o_done), 64'd0);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // mode: 0 ready always high, 1 random ready, 2 directed stall pattern; mess corrupts state_i and re-starts mid-stream
   task automatic burst(input bit s, input logic [4:0][63:0] x, input int mode, input bit mess);
      int          first = s ? 3 : 0;
      int          nb = s ? 2 : 5;
      int          p = 0, cyc = 0;
      bit          r;
      bit          pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
      logic [63:0] seq[$];
      for (int k = 0; k < nb; k++) seq.push_back(sw64(x[first + k]));
      sel = s;
      st = x;
      if (s) start_b = 1; else start_a = 1;
      tick();
      start_a = 0;
      start_b = 0;
      if (!mess) st = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      while (p < nb && cyc < 64) begin
         r = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : pat[cyc % 8];
         rdy = r;
         check("send.valid", 64'(o_valid), 64'd1);
         check("send.word",  o_word, seq[p]);
         check("send.index", 64'(o_index), 64'(first + p));
         check("send.last",  64'(o_last), 64'(p == nb - 1));
         check("send.busy",  64'(o_busy), 64'd1);
         check("send.done",  64'(o_done), 64'd0);
         if (mess && cyc == 1) begin
            st = '1;
            if (s) start_b = 1; else start_a = 1;
         end else begin
            start_a = 0;
            start_b = 0;
         end
         tick();
         if (r) p++;
         cyc++;
      end
      start_a = 0;
      start_b = 0;
      check("burst.transfers", 64'(p), 64'(nb));
      rdy = 1'($urandom_range(0, 1));
      check("done.valid", 64'(o_valid), 64'd0);
      check("done.word",  o_word, 64'd0);
      check("done.busy",  64'(o_busy), 64'd1);
      check("done.done",  64'(o_done), 64'd1);
      tick();
      check_idle("after_done");
   endtask
   initial begin
      logic [4:0][63:0] x;
      rst = 1; start_a = 0; start_b = 0; rdy = 0; st = '0; sel = 0;
      tick();
      tick();
      sel = 0; check_idle("reset_a");
      sel = 1; check_idle("reset_b");
      rst = 0;
      tick();
      for (int k = 0; k < 5; k++) x[k] = 64'h1111111111111111 * 64'(k);
      burst(0, x, 0, 0);
      burst(1, x, 0, 0);
      burst(0, x, 2, 0);
      for (int k = 0; k < 5; k++) x[k] = {$urandom, $urandom};
      burst(0, x, 0, 1);
      burst(1, x, 2, 1);
      // reset while index 2 is on the bus
      sel = 0;
      st = x;
      rdy = 1;
      start_a = 1;
      tick();
      start_a = 0;
      tick();
      tick();
      check("pre_reset.index", 64'(o_index), 64'd2);
      check("pre_reset.word", o_word, sw64(x[2]));
      rst = 1;
      tick();
      check_idle("in_reset");
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_reset.done", 64'(o_done), 64'd0);
      end
      rst = 1;
      start_a = 1;
      tick();
      rst = 0;
      start_a = 0;
      tick();
      check_idle("reset_beats_start");
      x[0] = 64'h0123456789ABCDEF;
      st = x;
      start_a = 1;
      tick();
      start_a = 0;
`ifdef ASCON_READER_BYTESWAP_EN
      check("byteswap.literal", o_word, 64'hEFCDAB8967452301);
`else
      check("byteswap.literal", o_word, 64'h0123456789ABCDEF);
`endif
      for (int i = 0; i < 6; i++) tick();
      check_idle("literal_drain");
      for (int n = 0; n < 12; n++) begin
         for (int k = 0; k < 5; k++) x[k] = {$urandom, $urandom};
         burst(1'(n % 2), x, 1, 1'(n % 3 == 0));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
